// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer: UART transmit serializer driven by baud_clk rising-edge ticks.
//
// Sends one frame per accepted word: a start bit, DATA_BITS data bits LSB-first, an
// optional parity bit, then STOP_BITS stop bits. The line idles high.
//
// Ports
//   clock         system clock
//   reset_n       asynchronous active-low reset
//   baud_clk_i    baud generator square wave; each rising edge is one bit tick
//   tx_data_i     word to send, sampled on accept
//   tx_valid_i    upstream offers a word
//   tx_ready_o    high while idle; accept = tx_valid_i & tx_ready_o at a clock edge
//   parity_en_i   insert a parity bit, sampled on accept
//   parity_odd_i  1 = odd parity, 0 = even parity, sampled on accept
//   tx_o          registered serial line output
//   tx_busy_o     high from accept until the frame ends
//   tx_done_o     one-cycle pulse when the last stop bit completes
module uart_tx_serializer #(
    parameter int DATA_BITS = 8,
    parameter int STOP_BITS = 1
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 baud_clk_i,
    input  logic [DATA_BITS-1:0] tx_data_i,
    input  logic                 tx_valid_i,
    output logic                 tx_ready_o,
    input  logic                 parity_en_i,
    input  logic                 parity_odd_i,
    output logic                 tx_o,
    output logic                 tx_busy_o,
    output logic                 tx_done_o
);
    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] SYNC   = 3'd1;
    localparam logic [2:0] START  = 3'd2;
    localparam logic [2:0] DATA   = 3'd3;
    localparam logic [2:0] PARITY = 3'd4;
    localparam logic [2:0] STOP   = 3'd5;
    localparam logic [2:0] LAST_BIT  = 3'(DATA_BITS - 1);
    localparam logic       LAST_STOP = 1'(STOP_BITS - 1);

    logic [2:0]           state_q, state_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [2:0]           bit_idx_q, bit_idx_d;
    logic                 stop_cnt_q, stop_cnt_d;
    logic                 par_en_q, par_en_d;
    logic                 par_bit_q, par_bit_d;
    logic                 tx_q, tx_d;
    logic                 done_q, done_d;
    logic                 baud_clk_q;
    logic                 tick;

    // baud_clk already comes from a flop in this clock domain, so a single delay
    // flop is enough to find its rising edge.
    assign tick       = baud_clk_i & ~baud_clk_q;
    assign tx_ready_o = state_q == IDLE;
    assign tx_busy_o  = state_q != IDLE;
    assign tx_o       = tx_q;
    assign tx_done_o  = done_q;

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bit_idx_d  = bit_idx_q;
        stop_cnt_d = stop_cnt_q;
        par_en_d   = par_en_q;
        par_bit_d  = par_bit_q;
        tx_d       = tx_q;
        done_d     = 1'b0;
        if (state_q == IDLE) begin
            // A tick landing in the accept cycle is deliberately ignored: SYNC
            // waits for the next one so the start bit is always a full bit long.
            if (tx_valid_i) begin
                shift_d   = tx_data_i;
                par_en_d  = parity_en_i;
                par_bit_d = parity_odd_i ^ (^tx_data_i);
                state_d   = SYNC;
            end
        end else if (tick) begin
            case (state_q)
                SYNC: begin
                    state_d = START;
                    tx_d    = 1'b0;
                end
                START: begin
                    state_d   = DATA;
                    tx_d      = shift_q[0];
                    bit_idx_d = 3'd0;
                end
                DATA: begin
                    // The shift register moves right so the bit on the line is
                    // always shift_q[0]; the next one to send is shift_q[1].
                    if (bit_idx_q < LAST_BIT) begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        shift_d   = shift_q >> 1;
                        tx_d      = shift_q[1];
                    end else if (par_en_q) begin
                        state_d = PARITY;
                        tx_d    = par_bit_q;
                    end else begin
                        state_d    = STOP;
                        tx_d       = 1'b1;
                        stop_cnt_d = 1'b0;
                    end
                end
                PARITY: begin
                    state_d    = STOP;
                    tx_d       = 1'b1;
                    stop_cnt_d = 1'b0;
                end
                STOP: begin
                    if (stop_cnt_q == LAST_STOP) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        stop_cnt_d = stop_cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                    tx_d    = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            bit_idx_q  <= 3'd0;
            stop_cnt_q <= 1'b0;
            par_en_q   <= 1'b0;
            par_bit_q  <= 1'b0;
            tx_q       <= 1'b1;
            done_q     <= 1'b0;
            baud_clk_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bit_idx_q  <= bit_idx_d;
            stop_cnt_q <= stop_cnt_d;
            par_en_q   <= par_en_d;
            par_bit_q  <= par_bit_d;
            tx_q       <= tx_d;
            done_q     <= done_d;
            baud_clk_q <= baud_clk_i;
        end
    end
endmodule

// File: tb/tb_uart_tx_serializer.sv
// tb_uart_tx_serializer: frame-level model plus directed checks for uart_tx_serializer.
//
// Instance 0 has one stop bit and instance 1 has two. Both share the clock, the
// reset and an 8-clock baud_clk.
module tb_uart_tx_serializer;
    logic            clock = 1'b0;
    logic            reset_n = 1'b0;
    logic [2:0]      bcnt = 3'd0;
    logic            baud;
    logic [1:0]      vld = 2'b00;
    logic [1:0][7:0] dat = '0;
    logic [1:0]      pen = 2'b00;
    logic [1:0]      pod = 2'b00;
    logic [1:0]      rdy_w, tx_w, busy_w, done_w;
    int              cyc = 0;
    int              n_chk = 0;
    int              n_fail = 0;

    always #5 clock = ~clock;
    always @(posedge clock) bcnt <= bcnt + 3'd1;
    always @(posedge clock) cyc <= cyc + 1;
    assign baud = bcnt[2];

    uart_tx_serializer #(.DATA_BITS(8), .STOP_BITS(1)) dut0 (
        .clock(clock), .reset_n(reset_n), .baud_clk_i(baud), .tx_data_i(dat[0]),
        .tx_valid_i(vld[0]), .tx_ready_o(rdy_w[0]), .parity_en_i(pen[0]),
        .parity_odd_i(pod[0]), .tx_o(tx_w[0]), .tx_busy_o(busy_w[0]), .tx_done_o(done_w[0])
    );

    uart_tx_serializer #(.DATA_BITS(8), .STOP_BITS(2)) dut1 (
        .clock(clock), .reset_n(reset_n), .baud_clk_i(baud), .tx_data_i(dat[1]),
        .tx_valid_i(vld[1]), .tx_ready_o(rdy_w[1]), .parity_en_i(pen[1]),
        .parity_odd_i(pod[1]), .tx_o(tx_w[1]), .tx_busy_o(busy_w[1]), .tx_done_o(done_w[1])
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    // Whole frame as a bit list, index 0 on the line first: start, data LSB-first,
    // optional parity, then stop bits (every remaining position is 1).
    function automatic logic [11:0] mk_frame(input logic [7:0] d, input logic pe, input logic po);
        logic [11:0] f;
        int ones;
        f = '1;
        f[0] = 1'b0;
        for (int k = 0; k < 8; k++) f[k+1] = d[k];
        ones = $countones(d);
        if (pe) f[9] = po ? (ones % 2 == 0) : (ones % 2 == 1);
        return f;
    endfunction

    // Model: idle (0), waiting for first tick (1), on the line (2) at position m_pos.
    int          m_ph[2];
    int          m_pos[2];
    int          m_len[2];
    logic [1:0][11:0] m_fr;
    logic [1:0]  m_tx, m_done;
    logic        m_bprev;

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            m_bprev <= 1'b0;
            m_tx    <= 2'b11;
            m_done  <= 2'b00;
            m_fr    <= '1;
            for (int i = 0; i < 2; i++) begin
                m_ph[i]  <= 0;
                m_pos[i] <= 0;
                m_len[i] <= 0;
            end
        end else begin
            m_bprev <= baud;
            for (int i = 0; i < 2; i++) begin
                m_done[i] <= 1'b0;
                if (m_ph[i] == 0) begin
                    if (vld[i]) begin
                        m_fr[i]  <= mk_frame(dat[i], pen[i], pod[i]);
                        m_len[i] <= 9 + int'(pen[i]) + (i == 0 ? 1 : 2);
                        m_ph[i]  <= 1;
                    end
                end else if (baud && !m_bprev) begin
                    if (m_ph[i] == 1) begin
                        m_ph[i]  <= 2;
                        m_pos[i] <= 0;
                        m_tx[i]  <= m_fr[i][0];
                    end else if (m_pos[i] == m_len[i] - 1) begin
                        m_ph[i]   <= 0;
                        m_tx[i]   <= 1'b1;
                        m_done[i] <= 1'b1;
                    end else begin
                        m_pos[i] <= m_pos[i] + 1;
                        m_tx[i]  <= m_fr[i][m_pos[i]+1];
                    end
                end
            end
        end
    end

    always @(negedge clock) begin
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("tx[%0d]", i), 32'(tx_w[i]), 32'(m_tx[i]));
            chk($sformatf("ready[%0d]", i), 32'(rdy_w[i]), 32'(m_ph[i] == 0));
            chk($sformatf("busy[%0d]", i), 32'(busy_w[i]), 32'(m_ph[i] != 0));
            chk($sformatf("done[%0d]", i), 32'(done_w[i]), 32'(m_done[i]));
        end
    end

    task automatic send(input int i, input logic [7:0] d, input logic pe, input logic po);
        @(posedge clock);
        #1;
        dat[i] = d;
        pen[i] = pe;
        pod[i] = po;
        vld[i] = 1'b1;
        @(posedge clock);
        #1;
        vld[i] = 1'b0;
        chk("ready low after accept", 32'(rdy_w[i]), 32'd0);
    endtask

    // Samples every bit of one frame mid-bit, then waits for the done pulse.
    task automatic rx(input int i, input int nb, output logic [11:0] bits, output int fc, output int dc);
        int n;
        bits = '1;
        fc = -1;
        dc = -1;
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (tx_w[i] !== 1'b0 && n < 300);
        chk("start bit seen", 32'(tx_w[i]), 32'd0);
        if (tx_w[i] !== 1'b0) return;
        fc = cyc;
        for (int k = 0; k < nb; k++) begin
            repeat (k == 0 ? 4 : 8) @(negedge clock);
            bits[k] = tx_w[i];
        end
        n = 0;
        while (done_w[i] !== 1'b1 && n < 200) begin
            @(negedge clock);
            n++;
        end
        chk("done seen", 32'(done_w[i]), 32'd1);
        dc = cyc;
    endtask

    logic [11:0] bits;
    int fc, dc, fc2, dc2, n;

    initial begin
        repeat (100) @(posedge clock);
        #1;
        chk("reset tx", 32'(tx_w), 32'b11);
        chk("reset ready", 32'(rdy_w), 32'b11);
        chk("reset busy", 32'(busy_w), 32'b00);
        chk("reset done", 32'(done_w), 32'b00);
        reset_n = 1'b1;

        // 0x55, no parity
        send(0, 8'h55, 1'b0, 1'b0);
        rx(0, 10, bits, fc, dc);
        chk("0x55 start", 32'(bits[0]), 32'd0);
        chk("0x55 data", 32'(bits[8:1]), 32'h55);
        chk("0x55 stop", 32'(bits[9]), 32'd1);
        chk("0x55 fall to done", 32'(dc - fc), 32'd80);
        @(negedge clock);
        chk("done one cycle", 32'(done_w[0]), 32'd0);

        // 0xA3 with even then odd parity
        send(0, 8'hA3, 1'b1, 1'b0);
        rx(0, 11, bits, fc, dc);
        chk("A3 even data", 32'(bits[8:1]), 32'hA3);
        chk("A3 even parity", 32'(bits[9]), 32'd0);
        chk("A3 even length", 32'(dc - fc), 32'd88);
        send(0, 8'hA3, 1'b1, 1'b1);
        rx(0, 11, bits, fc, dc);
        chk("A3 odd parity", 32'(bits[9]), 32'd1);
        chk("A3 odd stop", 32'(bits[10]), 32'd1);
        chk("A3 odd length", 32'(dc - fc), 32'd88);

        // Two stop bits, back-to-back with valid held
        @(posedge clock);
        #1;
        dat[1] = 8'h00;
        vld[1] = 1'b1;
        @(posedge clock);
        #1;
        dat[1] = 8'hFF;
        rx(1, 11, bits, fc, dc);
        chk("w0 data", 32'(bits[8:1]), 32'h00);
        chk("w0 stop bits", 32'(bits[10:9]), 32'b11);
        chk("w0 length", 32'(dc - fc), 32'd88);
        chk("ready in done cycle", 32'(rdy_w[1]), 32'd1);
        @(posedge clock);
        #1;
        chk("w1 accepted after done", 32'(busy_w[1]), 32'd1);
        vld[1] = 1'b0;
        rx(1, 11, bits, fc2, dc2);
        chk("w1 data", 32'(bits[8:1]), 32'hFF);
        chk("w1 start gap in 8..16", 32'((fc2 - dc) >= 8 && (fc2 - dc) <= 16), 32'd1);

        // Data change and extra valid during bit 2
        send(0, 8'h3C, 1'b0, 1'b0);
        fork
            rx(0, 10, bits, fc, dc);
            begin
                n = 0;
                do begin
                    @(negedge clock);
                    n++;
                end while (tx_w[0] !== 1'b0 && n < 300);
                repeat (24) @(negedge clock);
                dat[0] = 8'hC3;
                vld[0] = 1'b1;
                @(negedge clock);
                chk("busy ignores valid", 32'(rdy_w[0]), 32'd0);
                vld[0] = 1'b0;
            end
        join
        chk("in-flight data kept", 32'(bits[8:1]), 32'h3C);
        n = 0;
        repeat (40) begin
            @(negedge clock);
            if (tx_w[0] !== 1'b1 || busy_w[0] !== 1'b0) n++;
        end
        chk("no second frame", 32'(n), 32'd0);

        // Reset in the middle of data bit 3
        send(0, 8'h5A, 1'b0, 1'b0);
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (tx_w[0] !== 1'b0 && n < 300);
        repeat (36) @(negedge clock);
        #2;
        reset_n = 1'b0;
        #1;
        chk("reset mid-frame tx", 32'(tx_w[0]), 32'd1);
        chk("reset mid-frame busy", 32'(busy_w[0]), 32'd0);
        repeat (3) @(posedge clock);
        #1;
        reset_n = 1'b1;
        send(0, 8'h81, 1'b0, 1'b0);
        rx(0, 10, bits, fc, dc);
        chk("0x81 after reset", 32'(bits[9:0]), 32'b1_10000001_0);
        chk("0x81 length", 32'(dc - fc), 32'd80);

        repeat (20) @(negedge clock);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
